// File: rtl/sram_64x64_req_ctrl.sv
// Request/response front end for a 64x64 single-port SRAM macro.
// One transaction at a time; macro and response pins are all registered.
module sram_64x64_req_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_val,
    output logic                  req_rdy,
    input  logic                  req_type,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_val,
    input  logic                  resp_rdy,
    output logic                  resp_type,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  CE1,
    output logic                  CSB1,
    output logic                  WEB1,
    output logic                  OEB1,
    output logic [ADDR_WIDTH-1:0] A1,
    output logic [DATA_WIDTH-1:0] I1,
    input  logic [DATA_WIDTH-1:0] O1
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDWAIT,
        RESP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    typ_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    accept;
    logic                    consume;

    logic                    rdy_d;
    logic                    rval_d;
    logic                    rtype_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic                    ce_d;
    logic                    csb_d;
    logic                    web_d;
    logic                    oeb_d;
    logic [ADDR_WIDTH-1:0]   a_d;
    logic [DATA_WIDTH-1:0]   i_d;

    assign accept  = req_val & req_rdy & (state == IDLE);
    assign consume = resp_val & resp_rdy;

    // Pin registers are loaded from a decode of the current state, so the
    // visible phase on the macro and response pins trails the state by one.
    always_comb begin
        state_nxt = state;
        rdy_d     = 1'b0;
        rval_d    = 1'b0;
        rtype_d   = resp_type;
        rdata_d   = resp_data;
        ce_d      = (state != IDLE);
        csb_d     = (state != ACCESS);
        web_d     = !((state == ACCESS) && typ_q);
        oeb_d     = (state != RDWAIT);
        a_d       = A1;
        i_d       = I1;

        unique case (state)
            IDLE: begin
                if (accept) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = typ_q ? RESP : RDWAIT;
                a_d       = addr_q;
                if (typ_q) i_d = data_q;
            end
            RDWAIT: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (consume) state_nxt = IDLE;
                rval_d = !consume;
                if (!resp_val) begin
                    rtype_d = typ_q;
                    rdata_d = typ_q ? '0 : O1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        rdy_d = (state_nxt == IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            typ_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            req_rdy   <= 1'b0;
            resp_val  <= 1'b0;
            resp_type <= 1'b0;
            resp_data <= '0;
            CE1       <= 1'b0;
            CSB1      <= 1'b1;
            WEB1      <= 1'b1;
            OEB1      <= 1'b1;
            A1        <= '0;
            I1        <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                typ_q  <= req_type;
                addr_q <= req_addr;
                data_q <= req_data;
            end
            req_rdy   <= rdy_d;
            resp_val  <= rval_d;
            resp_type <= rtype_d;
            resp_data <= rdata_d;
            CE1       <= ce_d;
            CSB1      <= csb_d;
            WEB1      <= web_d;
            OEB1      <= oeb_d;
            A1        <= a_d;
            I1        <= i_d;
        end
    end

endmodule

// File: tb/tb_sram_64x64_req_ctrl.sv
// Scoreboard bench for sram_64x64_req_ctrl with a behavioural SRAM macro.
// Expected responses and macro accesses are queued at accept time.
module tb_sram_64x64_req_ctrl;

    localparam int DW = 64;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_val;
    logic          req_rdy;
    logic          req_type;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          resp_val;
    logic          resp_rdy;
    logic          resp_type;
    logic [DW-1:0] resp_data;
    logic          CE1;
    logic          CSB1;
    logic          WEB1;
    logic          OEB1;
    logic [AW-1:0] A1;
    logic [DW-1:0] I1;
    logic [DW-1:0] O1;

    sram_64x64_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
        .req_addr(req_addr), .req_data(req_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy),
        .resp_type(resp_type), .resp_data(resp_data),
        .CE1(CE1), .CSB1(CSB1), .WEB1(WEB1), .OEB1(OEB1),
        .A1(A1), .I1(I1), .O1(O1)
    );

    always #5 clk = ~clk;

    // Macro model: write on CSB1/WEB1 low, read data valid the next cycle only.
    logic [DW-1:0] mem [64];
    logic [DW-1:0] o1_q;
    assign O1 = o1_q;
    always @(posedge clk) begin
        if (!CSB1 && !WEB1) mem[A1] <= I1;
        if (!CSB1 && WEB1) o1_q <= mem[A1];
        else o1_q <= {$urandom, $urandom};
    end

    typedef struct {
        logic          typ;
        logic [DW-1:0] data;
        time           t_acc;
    } rsp_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] data;
    } acc_t;

    rsp_t          rsp_q[$];
    acc_t          acc_q[$];
    logic [DW-1:0] ref_mem [64];
    int            n_chk = 0;
    int            n_pass = 0;
    int            csb_cnt = 0;
    bit            rnd_bp = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_CE1"}, CE1, 0);
        chk({tag, "_CSB1"}, CSB1, 1);
        chk({tag, "_WEB1"}, WEB1, 1);
        chk({tag, "_OEB1"}, OEB1, 1);
        chk({tag, "_A1"}, A1, 0);
        chk({tag, "_I1"}, I1, 0);
        chk({tag, "_resp_val"}, resp_val, 0);
        chk({tag, "_resp_type"}, resp_type, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_req_rdy"}, req_rdy, 0);
    endtask

    // Call at a negedge or just after a posedge; returns just after accept.
    task automatic issue(input logic t, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit hold,
                         output time tacc);
        logic r;
        bit   ok;
        acc_t ac;
        rsp_t rs;
        req_type = t;
        req_addr = a;
        req_data = d;
        req_val  = 1'b1;
        ok       = 0;
        tacc     = 0;
        for (int i = 0; i < 300; i++) begin
            r = req_rdy;
            @(posedge clk);
            tacc = $time;
            #1;
            if (r) begin
                ok = 1;
                break;
            end
        end
        chk("accept_timeout", 64'(ok), 1);
        ac.addr = a;
        ac.wr   = t;
        ac.data = d;
        acc_q.push_back(ac);
        rs.typ   = t;
        rs.t_acc = tacc;
        if (t) begin
            ref_mem[a] = d;
            rs.data    = '0;
        end else begin
            rs.data = ref_mem[a];
        end
        rsp_q.push_back(rs);
        if (!hold) req_val = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && req_rdy) begin
                ok = 1;
                break;
            end
        end
        chk("drain_timeout", 64'(ok), 1);
    endtask

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1 resp_rdy = 1'($urandom_range(0, 1));
        end
    end

    // Response monitor.
    bit            in_resp = 0;
    logic          held_t;
    logic [DW-1:0] held_d;
    always @(negedge clk) begin
        if (!reset) begin
            in_resp = 0;
        end else if (resp_val) begin
            if (!in_resp) begin
                chk("resp_expected", 64'(rsp_q.size() > 0), 1);
                if (rsp_q.size() > 0) begin
                    chk("resp_type", resp_type, rsp_q[0].typ);
                    chk("resp_data", resp_data, rsp_q[0].data);
                    chk("resp_latency",
                        64'((($time - 5) - rsp_q[0].t_acc) / 10),
                        rsp_q[0].typ ? 2 : 3);
                end
                held_t  = resp_type;
                held_d  = resp_data;
                in_resp = 1;
            end else begin
                chk("held_type", resp_type, held_t);
                chk("held_data", resp_data, held_d);
            end
            if (resp_rdy) begin
                if (rsp_q.size() > 0) void'(rsp_q.pop_front());
                in_resp = 0;
            end
        end
    end

    // Macro pin monitor.
    always @(negedge clk) begin
        if (reset && !CSB1) begin
            acc_t e;
            csb_cnt++;
            chk("access_expected", 64'(acc_q.size() > 0), 1);
            if (acc_q.size() > 0) begin
                e = acc_q.pop_front();
                chk("A1", A1, e.addr);
                chk("WEB1", WEB1, !e.wr);
                if (e.wr) chk("I1", I1, e.data);
                chk("CE1_access", CE1, 1);
                chk("OEB1_access", OEB1, 1);
            end
        end
        if (reset && !OEB1) begin
            chk("rdwait_CSB1", CSB1, 1);
            chk("rdwait_WEB1", WEB1, 1);
            chk("rdwait_CE1", CE1, 1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        time  ta;
        time  tt[6];
        int   c0;
        bit   ok;
        logic t;
        logic [AW-1:0] bad [2];
        logic [DW-1:0] pat [2];

        reset    = 1'b1;
        req_val  = 1'b0;
        req_type = 1'b0;
        req_addr = '0;
        req_data = '0;
        resp_rdy = 1'b1;
        #1 reset = 1'b0;
        #1 chk_reset("por");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1 chk("rdy_low_at_release", req_rdy, 0);
        @(negedge clk);
        chk("rdy_after_reset", req_rdy, 1);

        issue(1, 6'd5, 64'hDEADBEEF_CAFEF00D, 0, ta);
        drain();
        issue(0, 6'd5, '0, 0, ta);
        drain();

        resp_rdy = 1'b0;
        issue(0, 6'd5, '0, 0, ta);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_val) begin
                ok = 1;
                break;
            end
        end
        chk("bp_resp_seen", 64'(ok), 1);
        repeat (4) begin
            @(negedge clk);
            chk("bp_req_rdy", req_rdy, 0);
            chk("bp_resp_val", resp_val, 1);
        end
        @(posedge clk);
        #1 resp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_rdy", req_rdy, 1);
        chk("bp_idle_val", resp_val, 0);

        for (int a = 0; a < 64; a++) begin
            issue(1, AW'(a), {$urandom, $urandom}, 1, ta);
        end
        req_val = 1'b0;
        drain();

        bad[0] = 6'd0;
        bad[1] = 6'd63;
        pat[0] = '1;
        pat[1] = '0;
        for (int k = 0; k < 2; k++) begin
            issue(1, bad[0], pat[k], 0, ta);
            issue(1, bad[1], pat[1-k], 0, ta);
            issue(0, bad[0], '0, 0, ta);
            issue(0, bad[1], '0, 0, ta);
            drain();
        end

        c0 = csb_cnt;
        for (int i = 0; i < 6; i++) begin
            issue(i < 3, AW'($urandom_range(0, 63)),
                  {$urandom, $urandom}, 1, tt[i]);
        end
        req_val = 1'b0;
        drain();
        chk("b2b_csb_pulses", 64'(csb_cnt - c0), 6);
        for (int i = 1; i < 6; i++) begin
            chk("b2b_spacing", 64'((tt[i] - tt[i-1]) / 10), i <= 3 ? 4 : 5);
        end

        rnd_bp = 1;
        for (int i = 0; i < 40; i++) begin
            t = 1'($urandom_range(0, 1));
            issue(t, AW'($urandom_range(0, 63)), {$urandom, $urandom},
                  bit'($urandom_range(0, 1)), ta);
            if ($urandom_range(0, 3) == 0) begin
                req_val = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        req_val = 1'b0;
        drain();
        rnd_bp   = 0;
        resp_rdy = 1'b1;

        issue(0, AW'($urandom_range(0, 63)), '0, 0, ta);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!OEB1) begin
                ok = 1;
                break;
            end
        end
        chk("rdwait_seen", 64'(ok), 1);
        #2 reset = 1'b0;
        #1 chk_reset("abort");
        rsp_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("no_resp_after_abort", resp_val, 0);
        end
        issue(0, 6'd63, '0, 0, ta);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram_64x64_req_ctrl.md
SRAM_64X64_REQ_CTRL -- requirements
Module: sram_64x64_req_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 64: data word width.
REQ-002 Parameter ADDR_WIDTH, default 6: word address width, 64 entries.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; the ports SHALL be named clk and reset, and the design SHALL NOT add any other clock or reset port.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  async active-low reset.
REQ-006 req_val  in  1  request valid.
REQ-007 req_rdy  out  1  request accepted when req_val&req_rdy.
REQ-008 req_type  in  1  0=read, 1=write.
REQ-009 req_addr  in  ADDR_WIDTH  word address.
REQ-010 req_data  in  DATA_WIDTH  write data.
REQ-011 resp_val  out  1  response valid.
REQ-012 resp_rdy  in  1  response consumed when resp_val&resp_rdy.
REQ-013 resp_type  out  1  echo of the request type.
REQ-014 resp_data  out  DATA_WIDTH  read data; 0 for writes.
REQ-015 CE1  out  1  macro clock enable; high in every state except IDLE.
REQ-016 CSB1  out  1  macro chip select, active-low.
REQ-017 WEB1  out  1  macro write enable, active-low.
REQ-018 OEB1  out  1  macro output enable, active-low.
REQ-019 A1  out  ADDR_WIDTH  macro address.
REQ-020 I1  out  DATA_WIDTH  macro write data.
REQ-021 O1  in  DATA_WIDTH  macro read data, valid the cycle after a read access.

Function
REQ-022 FSM states SHALL be IDLE, ACCESS, RDWAIT and RESP; all macro-side outputs SHALL be driven from registers.
REQ-023 req_rdy SHALL be 1 only in IDLE, and a request SHALL be accepted on a rising edge with req_val=1 in IDLE.
REQ-024 On acceptance, the FSM SHALL go IDLE->ACCESS and latch type, addr and data.
REQ-025 ACCESS SHALL last exactly one cycle with CSB1=0, A1=latched address, and WEB1=0 with I1=latched data for a write, or WEB1=1 for a read.
REQ-026 Write: ACCESS->RESP, with resp_type=1 and resp_data=0.
REQ-027 Read: ACCESS->RDWAIT, with CSB1=1, WEB1=1 and OEB1=0 in RDWAIT; O1 SHALL be captured into resp_data at the end of RDWAIT, then RDWAIT->RESP.
REQ-028 OEB1 SHALL be 0 only in RDWAIT.
REQ-029 CSB1 SHALL be 0 only in ACCESS, for exactly one cycle per transaction.
REQ-030 WEB1 SHALL be 1 in every state except a write ACCESS.
REQ-031 RESP SHALL drive resp_val=1 and hold resp_data and resp_type stable until resp_rdy=1, then go RESP->IDLE.
REQ-032 req_val SHALL be ignored outside IDLE, with no queuing.
REQ-033 Latency from accept edge to the first resp_val cycle SHALL be 2 cycles for a write and 3 cycles for a read.
REQ-034 Minimum spacing between accepts SHALL be 4 cycles for a write and 5 cycles for a read, with resp_rdy held at 1.
REQ-035 The address SHALL be used unmodified, with no wrap or increment; all 64 addresses, including 0 and 63, SHALL be legal.
REQ-036 A1 and I1 SHALL hold their last driven value in IDLE.

Reset
REQ-037 reset=0 SHALL immediately force state=IDLE, CE1=0, CSB1=1, WEB1=1, OEB1=1, A1=0, I1=0, resp_val=0, resp_type=0, resp_data=0 and req_rdy=0.
REQ-038 req_rdy SHALL rise to 1 in the first cycle after reset deasserts.
REQ-039 Reset asserted mid-transaction (ACCESS, RDWAIT or RESP) SHALL abort it without emitting a response; a write aborted in ACCESS MAY or MAY NOT have reached the macro.

Verification
REQ-040 Write addr 5, data 0xDEADBEEF_CAFEF00D -> one CSB1=0/WEB1=0 cycle with A1=5 and I1 equal to the data; resp_val 2 cycles after accept with resp_type=1 and resp_data=0.
REQ-041 Read addr 5 after REQ-040 -> CSB1=0/WEB1=1, then OEB1=0; resp_val 3 cycles after accept with resp_data=0xDEADBEEF_CAFEF00D.
REQ-042 Backpressure: resp_rdy=0 for 4 cycles -> resp_val and resp_data held; req_rdy=0 throughout; IDLE in the cycle after resp_rdy=1.
REQ-043 Boundaries: write and read addr 0 and 63 with data all-ones and all-zeros -> exact readback; no address alteration.
REQ-044 Back-to-back: req_val held high for 3 writes then 3 reads -> exactly 6 CSB1 pulses; accept spacing of 4 cycles for writes and 5 for reads.
REQ-045 Reset asserted during RDWAIT -> outputs at reset values immediately, no resp_val; a following read of addr 63 completes normally.
